// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: issues one operand pair to the signed or unsigned divider IP and holds its result for EX
module ex_div_ctrl #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            op_signed,
  input  logic            op_rem,
  input  logic [DW-1:0]   src1,
  input  logic [DW-1:0]   src2,
  input  logic            flush,
  input  logic            res_ack,
  output logic [1:0]      s_dvd_tvalid,
  output logic [1:0]      s_dvs_tvalid,
  input  logic [1:0]      s_dvd_tready,
  input  logic [1:0]      s_dvs_tready,
  output logic [DW-1:0]   s_dvd_tdata,
  output logic [DW-1:0]   s_dvs_tdata,
  input  logic [1:0]      m_tvalid,
  input  logic [2*DW-1:0] m_tdata_s,
  input  logic [2*DW-1:0] m_tdata_u,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   result
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;
  state_t state;
  logic sgn, rem, acc_dvd, acc_dvs, kill;
  logic [DW-1:0] a, b;
  logic [1:0] sel;
  logic hs_dvd, hs_dvs, nd, ns, mv;
  logic [2*DW-1:0] mdata;
  assign sel = sgn ? 2'b10 : 2'b01;
  assign s_dvd_tvalid = (state == ISSUE && !acc_dvd) ? sel : 2'b00;
  assign s_dvs_tvalid = (state == ISSUE && !acc_dvs) ? sel : 2'b00;
  assign s_dvd_tdata = a;
  assign s_dvs_tdata = b;
  assign hs_dvd = |(s_dvd_tvalid & s_dvd_tready);
  assign hs_dvs = |(s_dvs_tvalid & s_dvs_tready);
  assign nd = acc_dvd | hs_dvd;
  assign ns = acc_dvs | hs_dvs;
  assign mv = |(m_tvalid & sel);
  assign mdata = sgn ? m_tdata_s : m_tdata_u;
  assign busy = state == ISSUE || state == WAIT || state == DRAIN;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sgn     <= 1'b0;
      rem     <= 1'b0;
      a       <= '0;
      b       <= '0;
      acc_dvd <= 1'b0;
      acc_dvs <= 1'b0;
      kill    <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        IDLE:
          if (start && !flush) begin
            sgn   <= op_signed;
            rem   <= op_rem;
            a     <= src1;
            b     <= src2;
            state <= ISSUE;
          end
        ISSUE:
          if (flush && !nd && !ns) state <= IDLE;
          else if (nd && ns) begin
            state   <= (kill || flush) ? DRAIN : WAIT;
            acc_dvd <= 1'b0;
            acc_dvs <= 1'b0;
            kill    <= 1'b0;
          end else begin
            // a half-issued pair must still complete so the IP stays in step; its dout is drained
            acc_dvd <= nd;
            acc_dvs <= ns;
            kill    <= kill | flush;
          end
        WAIT: begin
          if (mv && !flush) result <= rem ? mdata[DW-1:0] : mdata[2*DW-1:DW];
          if (mv) state <= flush ? IDLE : DONE;
          else if (flush) state <= DRAIN;
        end
        DONE:  if (flush || res_ack) state <= IDLE;
        DRAIN: if (mv) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb_ex_div_ctrl: directed checks of ex_div_ctrl against a behavioural pair of divider IPs
module tb_ex_div_ctrl;
  logic clk = 1'b0;
  logic reset, start, op_signed, op_rem, flush, res_ack;
  logic [31:0] src1, src2, s_dvd_tdata, s_dvs_tdata, result;
  logic [1:0] s_dvd_tvalid, s_dvs_tvalid, s_dvd_tready, s_dvs_tready, m_tvalid;
  logic [1:0] mv_ip = 2'b00, stray;
  logic [63:0] m_tdata_s, m_tdata_u, ip_dout;
  logic busy, done;

  ex_div_ctrl #(.DW(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op_signed(op_signed), .op_rem(op_rem),
    .src1(src1), .src2(src2), .flush(flush), .res_ack(res_ack),
    .s_dvd_tvalid(s_dvd_tvalid), .s_dvs_tvalid(s_dvs_tvalid),
    .s_dvd_tready(s_dvd_tready), .s_dvs_tready(s_dvs_tready),
    .s_dvd_tdata(s_dvd_tdata), .s_dvs_tdata(s_dvs_tdata),
    .m_tvalid(m_tvalid), .m_tdata_s(m_tdata_s), .m_tdata_u(m_tdata_u),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // divider IP model: tready after a programmable stall, dout pulse lat cycles after both operands
  int dvd_dly = 0, dvs_dly = 0, lat = 10, cd = 0, cs = 0, lc = 0;
  int issued = 0, pulses = 0;
  logic got_a = 1'b0, got_b = 1'b0, ip_busy = 1'b0, ip_s = 1'b0;
  logic [31:0] cap_a, cap_b, op_a = 32'd0, op_b = 32'd1, q_s, r_s, q_u, r_u;
  logic hs_a, hs_b;
  assign s_dvd_tready = (cd >= dvd_dly) ? 2'b11 : 2'b00;
  assign s_dvs_tready = (cs >= dvs_dly) ? 2'b11 : 2'b00;
  assign hs_a = |(s_dvd_tvalid & s_dvd_tready);
  assign hs_b = |(s_dvs_tvalid & s_dvs_tready);
  assign q_s = $signed(op_a) / $signed(op_b);
  assign r_s = $signed(op_a) % $signed(op_b);
  assign q_u = op_a / op_b;
  assign r_u = op_a % op_b;
  assign m_tvalid = mv_ip | stray;
  assign m_tdata_s = ip_s ? ip_dout : 64'hDEADBEEF_DEADBEEF;
  assign m_tdata_u = ip_s ? 64'hDEADBEEF_DEADBEEF : ip_dout;

  always @(posedge clk) begin
    mv_ip <= 2'b00;
    if (reset) begin
      cd <= 0; cs <= 0; got_a <= 1'b0; got_b <= 1'b0; ip_busy <= 1'b0; pulses <= issued;
    end else begin
      cd <= (|s_dvd_tvalid && !hs_a) ? cd + 1 : 0;
      cs <= (|s_dvs_tvalid && !hs_b) ? cs + 1 : 0;
      if (hs_a) begin cap_a <= s_dvd_tdata; got_a <= 1'b1; ip_s <= s_dvd_tvalid[1]; end
      if (hs_b) begin cap_b <= s_dvs_tdata; got_b <= 1'b1; end
      if ((got_a || hs_a) && (got_b || hs_b)) begin
        got_a <= 1'b0; got_b <= 1'b0;
        op_a <= hs_a ? s_dvd_tdata : cap_a;
        op_b <= hs_b ? s_dvs_tdata : cap_b;
        ip_busy <= 1'b1; lc <= lat; issued <= issued + 1;
      end else if (ip_busy) begin
        if (lc <= 1) begin
          ip_busy <= 1'b0;
          mv_ip <= ip_s ? 2'b10 : 2'b01;
          pulses <= pulses + 1;
          ip_dout <= ip_s ? {q_s, r_s} : {q_u, r_u};
        end
        lc <= lc - 1;
      end
    end
  end

  int n_sa = 0, n_sb = 0, n_ua = 0, n_ub = 0, n_done = 0, viol = 0;
  always @(negedge clk) begin
    n_sa += int'(s_dvd_tvalid[1]); n_sb += int'(s_dvs_tvalid[1]);
    n_ua += int'(s_dvd_tvalid[0]); n_ub += int'(s_dvs_tvalid[0]);
    n_done += int'(done);
    if (issued - pulses > 1) viol++;
  end

  int nvec = 0, nerr = 0;
  int b_sa, b_sb, b_ua, b_ub, b_done;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_sa = n_sa; b_sb = n_sb; b_ua = n_ua; b_ub = n_ub; b_done = n_done;
  endtask

  task automatic launch(input logic sg, input logic rm, input logic [31:0] a, input logic [31:0] b,
                        input int dd, input int sd, input int lt);
    dvd_dly = dd; dvs_dly = sd; lat = lt;
    op_signed = sg; op_rem = rm; src1 = a; src2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; src1 = ~a; src2 = ~b; op_signed = ~sg; op_rem = ~rm;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    chk({tag, "_done"}, done, 1);
  endtask

  task automatic do_op(input string tag, input logic sg, input logic rm, input logic [31:0] a,
                       input logic [31:0] b, input int dd, input int sd, input int lt, input logic [31:0] exp);
    launch(sg, rm, a, b, dd, sd, lt);
    wait_done(tag);
    chk(tag, result, exp);
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    chk({tag, "_ack"}, done, 0);
  endtask

  int stable;
  logic [31:0] r0;
  initial begin
    reset = 1'b1; start = 1'b0; op_signed = 1'b0; op_rem = 1'b0; flush = 1'b0; res_ack = 1'b0;
    src1 = '0; src2 = '0; stray = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_tvalid", {s_dvd_tvalid, s_dvs_tvalid}, 0);

    snap();
    do_op("div_w", 1, 0, 100, -32'sd7, 0, 0, 10, 32'hFFFFFFF2);
    chk("div_w_dvd_s", n_sa - b_sa, 1);
    chk("div_w_dvs_s", n_sb - b_sb, 1);
    chk("div_w_u_idle", (n_ua - b_ua) + (n_ub - b_ub), 0);

    snap();
    do_op("mod_wu", 0, 1, 32'hFFFFFFFF, 16, 0, 3, 6, 32'hF);
    chk("mod_wu_dvd_u", n_ua - b_ua, 1);
    chk("mod_wu_dvs_u", n_ub - b_ub, 4);
    chk("mod_wu_s_idle", (n_sa - b_sa) + (n_sb - b_sb), 0);

    // flush four cycles into WAIT
    snap();
    launch(1, 0, 50, 5, 0, 0, 10);
    repeat (5) @(negedge clk);
    chk("wflush_busy", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("wflush_drain", busy, 1);
    repeat (20) @(negedge clk);
    chk("wflush_nodone", n_done - b_done, 0);
    chk("wflush_idle", busy, 0);
    do_op("mod_w", 1, 1, 7, 3, 0, 0, 5, 32'd1);

    // flush in ISSUE after the dividend is accepted but not the divisor
    snap();
    launch(0, 0, 9, 2, 0, 5, 4);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (20) @(negedge clk);
    chk("iflush_dvd", n_ua - b_ua, 1);
    chk("iflush_dvs", n_ub - b_ub, 6);
    chk("iflush_nodone", n_done - b_done, 0);
    chk("iflush_idle", busy, 0);

    // result held while ack is low
    launch(0, 0, 1000, 10, 0, 0, 3);
    wait_done("hold");
    r0 = result;
    stable = 0;
    repeat (5) begin
      @(negedge clk);
      if (done && result === r0) stable++;
    end
    chk("hold_stable", stable, 5);
    chk("hold_result", result, 100);
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    chk("hold_ack", done, 0);

    // flush while DONE discards the result
    launch(1, 0, 21, 4, 0, 0, 2);
    wait_done("dflush");
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("dflush_done", done, 0);
    chk("dflush_busy", busy, 0);

    do_op("b2b_divwu", 0, 0, 32'h80000000, 2, 1, 0, 4, 32'h40000000);
    do_op("b2b_modw", 1, 1, -32'sd7, 3, 0, 2, 1, 32'hFFFFFFFF);
    do_op("b2b_divw", 1, 0, -32'sd100, 7, 2, 2, 7, 32'hFFFFFFF2);

    // reset while in WAIT, then a stray dout pulse
    launch(1, 0, 20, 3, 0, 0, 10);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("wrst_busy", busy, 0);
    chk("wrst_done", done, 0);
    chk("wrst_result", result, 0);
    chk("wrst_tvalid", {s_dvd_tvalid, s_dvs_tvalid}, 0);
    reset = 1'b0;
    snap();
    repeat (3) @(negedge clk);
    stray = 2'b11;
    @(negedge clk);
    stray = 2'b00;
    repeat (15) @(negedge clk);
    chk("stray_done", n_done - b_done, 0);
    chk("stray_busy", busy, 0);
    do_op("post_rst", 1, 1, -32'sd100, 7, 0, 0, 3, 32'hFFFFFFFE);
    chk("inflight", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
